// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared codes and sizes for the reorder buffer
package reorder_buffer_pkg;

  localparam int DEF_ROB_DEPTH = 15;
  localparam int DEF_TAG_W     = 4;
  localparam int TAG_NONE      = 0;

  localparam logic [1:0] DEST_MEM    = 2'd0;
  localparam logic [1:0] DEST_REG    = 2'd1;
  localparam logic [1:0] DEST_BRANCH = 2'd2;
  localparam logic [1:0] DEST_JL     = 2'd3;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with CDB writeback,
// in-order commit broadcast and mispredict flush at the head
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [1:0]       issue_dest_type,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred_taken,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_value1,
  output logic [31:0]      query_value2,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  output logic             have_commit,
  output logic [TAG_W-1:0] entry_commit,
  output logic [1:0]       dest_type_commit,
  output logic [4:0]       destination_commit,
  output logic [31:0]      value_commit,
  output logic             flush_out,
  output logic [31:0]      redirect_pc
);

  localparam int SLOTS = 2 ** TAG_W;
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  logic [TAG_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [SLOTS-1:0] busy, ready;

  logic [1:0]  type_q   [SLOTS];
  logic [4:0]  rd_q     [SLOTS];
  logic [31:0] pc_q     [SLOTS];
  logic        pred_q   [SLOTS];
  logic [31:0] value_q  [SLOTS];
  logic        taken_q  [SLOTS];
  logic [31:0] target_q [SLOTS];

  logic commit_en, mispredict, alloc_en, wb_en;

  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(ROB_DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  assign issue_tag  = tail;
  assign rob_full   = (count == CNT_W'(ROB_DEPTH));
  assign commit_en  = rdy_in && busy[head] && ready[head];
  assign mispredict = commit_en && (type_q[head] == DEST_BRANCH) &&
                      (taken_q[head] != pred_q[head]);
  // A flushing commit drops whatever else arrives in the same cycle.
  assign alloc_en   = rdy_in && issue_valid && !rob_full && !mispredict;
  assign wb_en      = rdy_in && wb_valid && (wb_tag != TAG_W'(TAG_NONE)) &&
                      busy[wb_tag] && !mispredict;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head               <= TAG_W'(1);
      tail               <= TAG_W'(1);
      count              <= '0;
      busy               <= '0;
      ready              <= '0;
      have_commit        <= 1'b0;
      entry_commit       <= '0;
      dest_type_commit   <= '0;
      destination_commit <= '0;
      value_commit       <= '0;
      flush_out          <= 1'b0;
      redirect_pc        <= '0;
    end else if (!rdy_in) begin
      have_commit <= 1'b0;
      flush_out   <= 1'b0;
    end else begin
      have_commit <= commit_en;
      flush_out   <= mispredict;
      if (commit_en) begin
        entry_commit       <= head;
        dest_type_commit   <= type_q[head];
        destination_commit <= (type_q[head] == DEST_REG || type_q[head] == DEST_JL) ?
                              rd_q[head] : 5'd0;
        value_commit       <= value_q[head];
      end
      if (mispredict) begin
        redirect_pc <= taken_q[head] ? target_q[head] : pc_q[head] + 32'd4;
        head        <= TAG_W'(1);
        tail        <= TAG_W'(1);
        count       <= '0;
        busy        <= '0;
        ready       <= '0;
      end else begin
        if (wb_en) ready[wb_tag] <= 1'b1;
        if (alloc_en) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= next_ptr(tail);
        end
        if (commit_en) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= next_ptr(head);
        end
        count <= count + CNT_W'(alloc_en) - CNT_W'(commit_en);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (alloc_en) begin
      type_q[tail] <= issue_dest_type;
      rd_q[tail]   <= issue_rd;
      pc_q[tail]   <= issue_pc;
      pred_q[tail] <= issue_pred_taken;
    end
    if (wb_en) begin
      value_q[wb_tag]  <= wb_value;
      taken_q[wb_tag]  <= wb_taken;
      target_q[wb_tag] <= wb_target;
    end
  end

  // Same-cycle CDB bypass takes priority over the stored value.
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] tag);
    logic [32:0] r;
    r = '0;
    if (tag != TAG_W'(TAG_NONE) && busy[tag]) begin
      if (wb_valid && wb_tag == tag) r = {1'b1, wb_value};
      else if (ready[tag])           r = {1'b1, value_q[tag]};
    end
    return r;
  endfunction

  assign {query_ready1, query_value1} = lookup(query_tag1);
  assign {query_ready2, query_value2} = lookup(query_tag2);

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int TW = DEF_TAG_W;

  logic          clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic          issue_valid = 1'b0, issue_pred_taken = 1'b0;
  logic [1:0]    issue_dest_type = '0;
  logic [4:0]    issue_rd = '0;
  logic [31:0]   issue_pc = '0;
  logic [TW-1:0] issue_tag;
  logic          rob_full;
  logic [TW-1:0] query_tag1 = '0, query_tag2 = '0;
  logic          query_ready1, query_ready2;
  logic [31:0]   query_value1, query_value2;
  logic          wb_valid = 1'b0, wb_taken = 1'b0;
  logic [TW-1:0] wb_tag = '0;
  logic [31:0]   wb_value = '0, wb_target = '0;
  logic          have_commit, flush_out;
  logic [TW-1:0] entry_commit;
  logic [1:0]    dest_type_commit;
  logic [4:0]    destination_commit;
  logic [31:0]   value_commit, redirect_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_dest_type(issue_dest_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken), .issue_tag(issue_tag),
    .rob_full(rob_full), .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .wb_target(wb_target), .have_commit(have_commit), .entry_commit(entry_commit),
    .dest_type_commit(dest_type_commit), .destination_commit(destination_commit),
    .value_commit(value_commit), .flush_out(flush_out), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [TW-1:0] tag;
    logic [1:0]    dtype;
    logic [4:0]    rd;
    logic [31:0]   value;
  } commit_t;

  typedef struct {
    logic [TW-1:0] q1, q2;
    logic          wbv;
    logic [TW-1:0] wt;
    logic [31:0]   wv;
    logic          r1;
    logic [31:0]   v1;
    logic          r2;
    logic [31:0]   v2;
  } qvec_t;

  typedef struct {
    logic [1:0]  dtype;
    logic        pred, taken;
    logic [31:0] pc, target, value;
    logic        flush;
    logic [31:0] redirect;
  } bvec_t;

  commit_t       exp_q[$];
  commit_t       c;
  int            errors = 0, checks = 0, commit_cnt = 0;
  logic [TW-1:0] model_tail = TW'(1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest expected retirement.
  always @(negedge clk_in) begin
    if (rst_in && have_commit) begin
      commit_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got tag %0d expected none", entry_commit);
      end else begin
        c = exp_q.pop_front();
        chk("commit_tag", 32'(entry_commit), 32'(c.tag));
        chk("commit_type", 32'(dest_type_commit), 32'(c.dtype));
        chk("commit_rd", 32'(destination_commit), 32'(c.rd));
        chk("commit_value", value_commit, c.value);
      end
    end
  end

  task automatic push(input logic [TW-1:0] t, input logic [1:0] d, input logic [4:0] rd,
                      input logic [31:0] v);
    commit_t e;
    e.tag = t; e.dtype = d; e.rd = rd; e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic do_issue(input logic [1:0] d, input logic [4:0] rd, input logic [31:0] pc,
                          input logic pred, input bit accept);
    if (accept) chk("issue_tag", 32'(issue_tag), 32'(model_tail));
    issue_valid = 1'b1; issue_dest_type = d; issue_rd = rd;
    issue_pc = pc; issue_pred_taken = pred;
    @(negedge clk_in);
    issue_valid = 1'b0;
    if (accept) model_tail = (model_tail == TW'(DEF_ROB_DEPTH)) ? TW'(1) : model_tail + TW'(1);
  endtask

  task automatic do_wb(input logic [TW-1:0] t, input logic [31:0] v, input logic tk,
                       input logic [31:0] tgt);
    wb_valid = 1'b1; wb_tag = t; wb_value = v; wb_taken = tk; wb_target = tgt;
    @(negedge clk_in);
    wb_valid = 1'b0;
  endtask

  task automatic wait_commit(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk_in);
      seen = have_commit;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no commit expected one within 10 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    exp_q.delete();
    model_tail = TW'(1);
    #1;
    chk("rst_have_commit", 32'(have_commit), 32'd0);
    chk("rst_entry_commit", 32'(entry_commit), 32'd0);
    chk("rst_dest_type", 32'(dest_type_commit), 32'd0);
    chk("rst_destination", 32'(destination_commit), 32'd0);
    chk("rst_value_commit", value_commit, 32'd0);
    chk("rst_flush_out", 32'(flush_out), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_issue_tag", 32'(issue_tag), 32'd1);
    chk("rst_rob_full", 32'(rob_full), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  qvec_t         qv[6];
  bvec_t         bv[4];
  logic [TW-1:0] t_br, t_op;
  int            snap;

  initial begin
    qv[0] = '{4'd0, 4'd3, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h33};
    qv[1] = '{4'd2, 4'd2, 1'b1, 4'd2, 32'h55, 1'b1, 32'h55, 1'b1, 32'h55};
    qv[2] = '{4'd2, 4'd1, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0};
    qv[3] = '{4'd0, 4'd0, 1'b1, 4'd0, 32'h99, 1'b0, 32'h0,  1'b0, 32'h0};
    qv[4] = '{4'd7, 4'd3, 1'b1, 4'd1, 32'h77, 1'b0, 32'h0,  1'b1, 32'h33};
    qv[5] = '{4'd1, 4'd7, 1'b1, 4'd1, 32'h77, 1'b1, 32'h77, 1'b0, 32'h0};

    bv[0] = '{DEST_BRANCH, 1'b0, 1'b1, 32'h40,   32'h100,  32'h0,    1'b1, 32'h100};
    bv[1] = '{DEST_BRANCH, 1'b1, 1'b0, 32'h200,  32'h300,  32'h0,    1'b1, 32'h204};
    bv[2] = '{DEST_BRANCH, 1'b1, 1'b1, 32'h80,   32'h180,  32'h0,    1'b0, 32'h0};
    bv[3] = '{DEST_JL,     1'b0, 1'b1, 32'h1000, 32'h2000, 32'h1004, 1'b0, 32'h0};

    do_reset();

    // Out-of-order writeback, in-order retirement on consecutive cycles.
    push(model_tail, DEST_REG, 5'd5, 32'hC); do_issue(DEST_REG, 5'd5, 32'h0, 1'b0, 1);
    push(model_tail, DEST_REG, 5'd6, 32'hB); do_issue(DEST_REG, 5'd6, 32'h4, 1'b0, 1);
    push(model_tail, DEST_REG, 5'd7, 32'hA); do_issue(DEST_REG, 5'd7, 32'h8, 1'b0, 1);
    do_wb(4'd3, 32'hA, 1'b0, 32'h0);
    do_wb(4'd2, 32'hB, 1'b0, 32'h0);
    do_wb(4'd1, 32'hC, 1'b0, 32'h0);
    wait_commit("inorder");
    @(negedge clk_in); chk("inorder_second", 32'(have_commit), 32'd1);
    @(negedge clk_in); chk("inorder_third", 32'(have_commit), 32'd1);
    @(negedge clk_in); chk("inorder_done", 32'(have_commit), 32'd0);

    // Mid-run reset with five live entries.
    for (int i = 0; i < 5; i++) do_issue(DEST_REG, 5'(i + 1), 32'(i * 4), 1'b0, 1);
    do_reset();

    // Operand query table with same-cycle CDB bypass.
    do_issue(DEST_REG, 5'd1, 32'h0, 1'b0, 1);
    do_issue(DEST_REG, 5'd2, 32'h4, 1'b0, 1);
    do_issue(DEST_REG, 5'd3, 32'h8, 1'b0, 1);
    do_wb(4'd3, 32'h33, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      query_tag1 = qv[i].q1; query_tag2 = qv[i].q2;
      wb_valid = qv[i].wbv; wb_tag = qv[i].wt; wb_value = qv[i].wv;
      #1;
      chk($sformatf("q%0d_ready1", i), 32'(query_ready1), 32'(qv[i].r1));
      chk($sformatf("q%0d_value1", i), query_value1, qv[i].v1);
      chk($sformatf("q%0d_ready2", i), 32'(query_ready2), 32'(qv[i].r2));
      chk($sformatf("q%0d_value2", i), query_value2, qv[i].v2);
      wb_valid = 1'b0; query_tag1 = '0; query_tag2 = '0;
      @(negedge clk_in);
    end
    push(4'd1, DEST_REG, 5'd1, 32'h11);
    push(4'd2, DEST_REG, 5'd2, 32'h22);
    push(4'd3, DEST_REG, 5'd3, 32'h33);
    do_wb(4'd1, 32'h11, 1'b0, 32'h0);
    do_wb(4'd2, 32'h22, 1'b0, 32'h0);
    repeat (6) @(negedge clk_in);
    chk("query_drained", 32'(exp_q.size()), 32'd0);

    // Fill to capacity, refused 16th issue, wrap to tag 1.
    do_reset();
    for (int i = 0; i < DEF_ROB_DEPTH; i++) begin
      if (i == DEF_ROB_DEPTH - 1) chk("full_at_14", 32'(rob_full), 32'd0);
      do_issue(DEST_REG, 5'(i + 1), 32'(i * 4), 1'b0, 1);
    end
    chk("full_at_15", 32'(rob_full), 32'd1);
    do_issue(DEST_REG, 5'd30, 32'h999, 1'b0, 0);
    chk("full_after_16th", 32'(rob_full), 32'd1);
    chk("tag_after_16th", 32'(issue_tag), 32'd1);
    push(4'd1, DEST_REG, 5'd1, 32'h1);
    do_wb(4'd1, 32'h1, 1'b0, 32'h0);
    wait_commit("full_commit");
    chk("not_full_after_commit", 32'(rob_full), 32'd0);
    do_issue(DEST_REG, 5'd20, 32'h500, 1'b0, 1);
    chk("full_after_reissue", 32'(rob_full), 32'd1);
    chk("tag_after_reissue", 32'(issue_tag), 32'd2);

    // Branch / jump-and-link commit table, each with a younger op behind it.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      t_br = model_tail; do_issue(bv[i].dtype, 5'd1, bv[i].pc, bv[i].pred, 1);
      t_op = model_tail; do_issue(DEST_REG, 5'd9, 32'h0, 1'b0, 1);
      push(t_br, bv[i].dtype, (bv[i].dtype == DEST_JL) ? 5'd1 : 5'd0, bv[i].value);
      if (!bv[i].flush) push(t_op, DEST_REG, 5'd9, 32'h99);
      do_wb(t_op, 32'h99, 1'b0, 32'h0);
      do_wb(t_br, bv[i].value, bv[i].taken, bv[i].target);
      wait_commit($sformatf("br%0d", i));
      chk($sformatf("br%0d_flush", i), 32'(flush_out), 32'(bv[i].flush));
      if (bv[i].flush) begin
        chk($sformatf("br%0d_redirect", i), redirect_pc, bv[i].redirect);
        model_tail = TW'(1);
      end
      @(negedge clk_in);
      chk($sformatf("br%0d_flush_pulse", i), 32'(flush_out), 32'd0);
      repeat (4) @(negedge clk_in);
      chk($sformatf("br%0d_drained", i), 32'(exp_q.size()), 32'd0);
      chk($sformatf("br%0d_next_tag", i), 32'(issue_tag), 32'(model_tail));
    end

    // Global stall with the head ready.
    t_op = model_tail;
    do_issue(DEST_REG, 5'd3, 32'h0, 1'b0, 1);
    push(t_op, DEST_REG, 5'd3, 32'h66);
    do_wb(t_op, 32'h66, 1'b0, 32'h0);
    rdy_in = 1'b0;
    snap = commit_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk($sformatf("stall%0d_no_commit", i), 32'(have_commit), 32'd0);
    end
    rdy_in = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("stall_one_commit", 32'(commit_cnt - snap), 32'd1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
